ascon_serial_ctrl: RTL and testbench

//  Sequencer that runs one Ascon encrypt/decrypt job at a time through the bit-serial Ascon wrapper.
//  - Accepts a parallel job from the host side.
//  - Resets the wrapper and serialises key, nonce, AD and data into it, then pulses start.
//  - Deserialises the output data and tag, and returns them as one parallel response.

---
 rtl/ascon_serial_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ascon_serial_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_serial_ctrl.sv
// Sequencer for one Ascon job at a time through the bit-serial Ascon wrapper.
// Takes a parallel job, resets the wrapper, shifts key/nonce/AD/data in MSB first,
// pulses start, waits for ready, then shifts data and tag back out into one response.
`timescale 1ns/1ps

module ascon_serial_ctrl #(
   parameter int K       = 128,
   parameter int L       = 32,
   parameter int Y       = 200,
   parameter int TIMEOUT = 4096
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [K-1:0] req_key,
   input  logic [127:0] req_nonce,
   input  logic [L-1:0] req_ad,
   input  logic [Y-1:0] req_data,
   input  logic         req_decrypt,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [Y-1:0] resp_data,
   output logic [127:0] resp_tag,
   output logic         resp_timeout,
   output logic         busy,
   output logic         core_rst,
   output logic         keyxSI,
   output logic         noncexSI,
   output logic         associated_dataxSI,
   output logic         input_dataxSI,
   output logic         ascon_startxSI,
   output logic         decrypt,
   input  logic         output_dataxSO,
   input  logic         tagxSO,
   input  logic         ascon_readyxSO
);

   // Serial lengths: N bits go into the wrapper, M bits come back out.
   localparam int N0   = (K > 128) ? K : 128;
   localparam int N1   = (N0 > L) ? N0 : L;
   localparam int N    = (N1 > Y) ? N1 : Y;
   localparam int M    = (Y > 128) ? Y : 128;
   localparam int C0   = (N > M) ? N : M;
   localparam int CMAX = (C0 > TIMEOUT) ? C0 : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_SHIFT, S_ARM, S_START, S_WAIT, S_COLLECT, S_DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            skip;
   logic [K-1:0]    key_sr;
   logic [127:0]    nonce_sr;
   logic [L-1:0]    ad_sr;
   logic [Y-1:0]    data_sr;

   // Job sequencer: state, counters, field shifters and every registered output.
   // NOTE: state and outputs are registers, so every assignment here is non-blocking;
   // the request latches are cleared on reset too, so a reset mid-job leaves no stale bits behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         cnt                <= '0;
         skip               <= 1'b0;
         key_sr             <= '0;
         nonce_sr           <= '0;
         ad_sr              <= '0;
         data_sr            <= '0;
         req_ready          <= 1'b1;
         resp_valid         <= 1'b0;
         resp_data          <= '0;
         resp_tag           <= '0;
         resp_timeout       <= 1'b0;
         busy               <= 1'b0;
         core_rst           <= 1'b1;
         keyxSI             <= 1'b0;
         noncexSI           <= 1'b0;
         associated_dataxSI <= 1'b0;
         input_dataxSI      <= 1'b0;
         ascon_startxSI     <= 1'b0;
         decrypt            <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  key_sr    <= req_key;
                  nonce_sr  <= req_nonce;
                  ad_sr     <= req_ad;
                  data_sr   <= req_data;
                  decrypt   <= req_decrypt;
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_RST;
               end
            end
            S_RST: begin
               core_rst <= 1'b0;
               cnt      <= '0;
               state    <= S_SHIFT;
            end
            S_SHIFT: begin
               if (cnt == CW'(N - 1)) begin
                  state <= S_ARM;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_ARM: begin
               // The wrapper only honours start once its own count has passed N.
               ascon_startxSI <= 1'b1;
               state          <= S_START;
            end
            S_START: begin
               ascon_startxSI <= 1'b0;
               cnt            <= '0;
               state          <= S_WAIT;
            end
            S_WAIT: begin
               if (ascon_readyxSO) begin
                  cnt   <= '0;
                  skip  <= 1'b1;
                  state <= S_COLLECT;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  resp_timeout <= 1'b1;
                  resp_valid   <= 1'b1;
                  resp_data    <= '0;
                  resp_tag     <= '0;
                  state        <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_COLLECT: begin
               // The wrapper presents bit 0 one cycle after ready, so the first cycle is skipped.
               if (skip) begin
                  skip <= 1'b0;
               end else begin
                  // Shift in from the top: after the last shift, serial bit c sits at index c.
                  if (cnt < CW'(Y))   resp_data <= {output_dataxSO, resp_data[Y-1:1]};
                  if (cnt < CW'(128)) resp_tag  <= {tagxSO, resp_tag[127:1]};
                  if (cnt == CW'(M - 1)) begin
                     resp_valid <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (resp_ready) begin
                  resp_valid   <= 1'b0;
                  resp_timeout <= 1'b0;
                  req_ready    <= 1'b1;
                  busy         <= 1'b0;
                  core_rst     <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Emit the next MSB of every field. RST emits bit 0 so it is on the wires in SHIFT n=0;
         // after N emits every shifter has drained to zero, so the wires fall to 0 on leaving SHIFT.
         if (state == S_RST || state == S_SHIFT) begin
            keyxSI             <= key_sr[K-1];
            noncexSI           <= nonce_sr[127];
            associated_dataxSI <= ad_sr[L-1];
            input_dataxSI      <= data_sr[Y-1];
            key_sr             <= key_sr << 1;
            nonce_sr           <= nonce_sr << 1;
            ad_sr              <= ad_sr << 1;
            data_sr            <= data_sr << 1;
         end
      end
   end

endmodule

// File: tb/tb_ascon_serial_ctrl.sv
// Directed bench for ascon_serial_ctrl. A behavioural stand-in for the serial wrapper
// deserialises the inputs, produces a reversible keystream result and a tag, and
// serialises them back with the wrapper's one-cycle output delay.
`timescale 1ns/1ps

module tb_ascon_serial_ctrl;

   localparam int K       = 128;
   localparam int L       = 32;
   localparam int Y       = 200;
   localparam int N       = 200;
   localparam int M       = 200;
   localparam int TO      = 16;
   localparam int RDY_DLY = 5;
   localparam int LAT     = 1 + 1 + N + 1 + 1 + (RDY_DLY + 1) + 1 + M;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_decrypt;
   logic [K-1:0] req_key;
   logic [127:0] req_nonce;
   logic [L-1:0] req_ad;
   logic [Y-1:0] req_data;
   logic         resp_valid, resp_ready, resp_timeout, busy, core_rst;
   logic [Y-1:0] resp_data;
   logic [127:0] resp_tag;
   logic         keyxSI, noncexSI, associated_dataxSI, input_dataxSI, ascon_startxSI, decrypt;
   logic         output_dataxSO, tagxSO, ascon_readyxSO;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ascon_serial_ctrl #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_data(req_data),
      .req_decrypt(req_decrypt),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag), .resp_timeout(resp_timeout),
      .busy(busy), .core_rst(core_rst),
      .keyxSI(keyxSI), .noncexSI(noncexSI), .associated_dataxSI(associated_dataxSI),
      .input_dataxSI(input_dataxSI), .ascon_startxSI(ascon_startxSI), .decrypt(decrypt),
      .output_dataxSO(output_dataxSO), .tagxSO(tagxSO), .ascon_readyxSO(ascon_readyxSO)
   );

   // Reversible stand-in cipher: the same keystream XOR encrypts and decrypts.
   function automatic logic [Y-1:0] model_out(input logic [Y-1:0] d, input logic [K-1:0] k,
                                              input logic [127:0] n);
      return d ^ {k[71:0], n} ^ {n, k[127:56]};
   endfunction

   // Tag depends on key, nonce, AD and the plaintext, so encrypt and decrypt agree.
   function automatic logic [127:0] model_tag(input logic [K-1:0] k, input logic [127:0] n,
                                              input logic [L-1:0] a, input logic [Y-1:0] p);
      return k ^ {n[63:0], n[127:64]} ^ {96'h0, a} ^ p[127:0] ^ {56'h0, p[199:128]};
   endfunction

   // ---------------- wrapper stand-in ----------------
   logic [K-1:0] key_s;
   logic [127:0] nonce_s;
   logic [L-1:0] ad_s;
   logic [Y-1:0] data_s;
   logic         dec_s;
   int           scnt, wcnt, rcnt, start_scnt;
   bit           started, rdy, pad_err, never_ready;
   logic [Y-1:0] out_vec;
   logic [127:0] tag_vec;

   always @(posedge clk) begin
      if (core_rst) begin
         scnt <= 0; wcnt <= 0; rcnt <= 0;
         started <= 1'b0; rdy <= 1'b0; pad_err <= 1'b0;
      end else begin
         if (scnt < N) begin
            if (scnt < K) key_s[K-1-scnt] <= keyxSI;
            else if (keyxSI) pad_err <= 1'b1;
            if (scnt < 128) nonce_s[127-scnt] <= noncexSI;
            else if (noncexSI) pad_err <= 1'b1;
            if (scnt < L) ad_s[L-1-scnt] <= associated_dataxSI;
            else if (associated_dataxSI) pad_err <= 1'b1;
            if (scnt < Y) data_s[Y-1-scnt] <= input_dataxSI;
            else if (input_dataxSI) pad_err <= 1'b1;
         end
         if (scnt < 100000) scnt <= scnt + 1;
         if (ascon_startxSI && !started) begin
            started    <= 1'b1;
            start_scnt <= scnt;
            dec_s      <= decrypt;
         end
         if (started && !rdy && !never_ready) begin
            wcnt <= wcnt + 1;
            if (wcnt == RDY_DLY - 1) rdy <= 1'b1;
         end
         if (rdy) rcnt <= rcnt + 1;
      end
   end

   assign out_vec        = model_out(data_s, key_s, nonce_s);
   assign tag_vec        = model_tag(key_s, nonce_s, ad_s, dec_s ? out_vec : data_s);
   assign ascon_readyxSO = rdy;
   assign output_dataxSO = (rdy && rcnt >= 2 && rcnt - 2 < Y)   ? out_vec[rcnt-2] : 1'b0;
   assign tagxSO         = (rdy && rcnt >= 2 && rcnt - 2 < 128) ? tag_vec[rcnt-2] : 1'b0;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [K-1:0] k, input logic [127:0] n, input logic [L-1:0] a,
                        input logic [Y-1:0] d, input logic dec);
      req_key = k; req_nonce = n; req_ad = a; req_data = d; req_decrypt = dec;
      req_valid = 1'b1;
      check("idle_req_ready", 256'(req_ready), 256'(1));
   endtask

   // Called with the handshake on the next posedge; walks negedges until resp_valid.
   task automatic run_job(input bit keep_valid, output int lat, output int st_lat,
                          output int st_len, output int fall_lat, output int falls,
                          output bit rr_seen);
      logic prev;
      lat = 0; st_lat = -1; st_len = 0; fall_lat = -1; falls = 0; rr_seen = 1'b0;
      prev = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (!keep_valid) req_valid = 1'b0;
         if (ascon_startxSI) begin
            if (st_lat < 0) st_lat = lat;
            st_len++;
         end
         if (prev && !core_rst) begin
            falls++;
            if (fall_lat < 0) fall_lat = lat;
         end
         prev = core_rst;
         if (req_ready) rr_seen = 1'b1;
      end while (!resp_valid && lat < 3000);
      check("resp_valid_reached", 256'(resp_valid), 256'(1));
   endtask

   task automatic check_result(input string tag, input logic [K-1:0] k, input logic [127:0] n,
                               input logic [L-1:0] a, input logic [Y-1:0] d, input logic dec);
      logic [Y-1:0] plain;
      plain = dec ? model_out(d, k, n) : d;
      check({tag, "_key_in"},   256'(key_s),   256'(k));
      check({tag, "_nonce_in"}, 256'(nonce_s), 256'(n));
      check({tag, "_ad_in"},    256'(ad_s),    256'(a));
      check({tag, "_data_in"},  256'(data_s),  256'(d));
      check({tag, "_pad"},      256'(pad_err), 256'(0));
      check({tag, "_decrypt"},  256'(decrypt), 256'(dec));
      check({tag, "_start_at"}, 256'(start_scnt), 256'(N + 1));
      check({tag, "_data"},     256'(resp_data), 256'(model_out(d, k, n)));
      check({tag, "_tag"},      256'(resp_tag),  256'(model_tag(k, n, a, plain)));
      check({tag, "_timeout"},  256'(resp_timeout), 256'(0));
      check({tag, "_busy"},     256'(busy), 256'(1));
   endtask

   task automatic release_resp(input string tag);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, "_rel_valid"}, 256'(resp_valid), 256'(0));
      check({tag, "_rel_ready"}, 256'(req_ready),  256'(1));
      check({tag, "_rel_busy"},  256'(busy),       256'(0));
      check({tag, "_rel_crst"},  256'(core_rst),   256'(1));
   endtask

   initial begin
      #300_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [K-1:0] key_d, key_2;
      logic [127:0] nonce_d, nonce_2;
      logic [L-1:0] ad_d, ad_2;
      logic [Y-1:0] data_0, data_a, data_b, ct1;
      logic [127:0] tag1;
      logic [Y-1:0] held_d;
      logic [127:0] held_t;
      int  lat, st_lat, st_len, fall_lat, falls;
      bit  rr_seen, stable;

      key_d   = 128'h000102030405060708090A0B0C0D0E0F;
      nonce_d = 128'h000102030405060708090A0B0C0D0E0F;
      ad_d    = 32'h41534344;
      data_0  = '0;
      key_2   = 128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE;
      nonce_2 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
      ad_2    = 32'hA5A5_0F0F;
      data_a  = 200'hC3_0102030405060708_1122334455667788_99AABBCCDDEEFF00;
      data_b  = 200'h01_FFFFFFFFFFFFFFFF_0000000000000000_8000000000000001;

      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; never_ready = 1'b0;
      req_key = '0; req_nonce = '0; req_ad = '0; req_data = '0; req_decrypt = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_req_ready",  256'(req_ready),  256'(1));
      check("rst_core_rst",   256'(core_rst),   256'(1));
      check("rst_busy",       256'(busy),       256'(0));
      check("rst_resp_valid", 256'(resp_valid), 256'(0));
      check("rst_start",      256'(ascon_startxSI), 256'(0));
      check("rst_serial",     256'({keyxSI, noncexSI, associated_dataxSI, input_dataxSI, decrypt}), 256'(0));
      check("rst_resp_data",  256'(resp_data), 256'(0));
      check("rst_resp_tag",   256'(resp_tag),  256'(0));
      rst = 1'b0;
      @(negedge clk);

      // 1. Default encrypt job
      issue(key_d, nonce_d, ad_d, data_0, 1'b0);
      run_job(1'b0, lat, st_lat, st_len, fall_lat, falls, rr_seen);
      check("t1_latency",   256'(lat), 256'(LAT));
      check("t1_rst_fall",  256'(fall_lat), 256'(2));
      check("t1_shift_len", 256'(st_lat - fall_lat - 1), 256'(N));
      check("t1_start_len", 256'(st_len), 256'(1));
      check("t1_ready_low", 256'(rr_seen), 256'(0));
      check_result("t1", key_d, nonce_d, ad_d, data_0, 1'b0);
      ct1  = resp_data;
      tag1 = resp_tag;
      release_resp("t1");

      // 2. Round trip, with 3. response backpressure on its result
      issue(key_d, nonce_d, ad_d, ct1, 1'b1);
      run_job(1'b0, lat, st_lat, st_len, fall_lat, falls, rr_seen);
      check_result("t2", key_d, nonce_d, ad_d, ct1, 1'b1);
      check("t2_plain", 256'(resp_data), 256'(data_0));
      check("t2_tag_eq_t1", 256'(resp_tag), 256'(tag1));
      held_d = resp_data;
      held_t = resp_tag;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!resp_valid || req_ready || resp_data !== held_d || resp_tag !== held_t) stable = 1'b0;
      end
      check("t3_stable_20", 256'(stable), 256'(1));
      check("t3_data_held", 256'(resp_data), 256'(model_out(ct1, key_d, nonce_d)));
      release_resp("t3");

      // 4. Timeout: wrapper never raises ready
      never_ready = 1'b1;
      issue(key_2, nonce_2, ad_2, data_a, 1'b0);
      run_job(1'b0, lat, st_lat, st_len, fall_lat, falls, rr_seen);
      check("t4_timeout",  256'(resp_timeout), 256'(1));
      check("t4_data",     256'(resp_data), 256'(0));
      check("t4_tag",      256'(resp_tag),  256'(0));
      check("t4_wait_len", 256'(lat - st_lat), 256'(TO + 1));
      release_resp("t4");
      check("t4_timeout_cleared", 256'(resp_timeout), 256'(0));
      never_ready = 1'b0;

      // 5. Reset at SHIFT n = 57 (SHIFT n=0 is the second cycle after the handshake)
      issue(key_2, nonce_2, ad_2, data_a, 1'b0);
      for (int i = 0; i < 2 + 57; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_req_ready", 256'(req_ready), 256'(1));
      check("t5_core_rst",  256'(core_rst),  256'(1));
      check("t5_busy",      256'(busy),      256'(0));
      check("t5_serial",    256'({keyxSI, noncexSI, associated_dataxSI, input_dataxSI, ascon_startxSI}), 256'(0));
      @(negedge clk);
      issue(key_2, nonce_2, ad_2, data_a, 1'b0);
      run_job(1'b0, lat, st_lat, st_len, fall_lat, falls, rr_seen);
      check("t5_latency", 256'(lat), 256'(LAT));
      check_result("t5", key_2, nonce_2, ad_2, data_a, 1'b0);
      release_resp("t5");

      // 6. Back-to-back with req_valid held high; second job's fields appear after the first handshake
      issue(key_2, nonce_2, ad_2, data_a, 1'b0);
      @(posedge clk);
      #1;
      req_key = key_d; req_nonce = nonce_d; req_ad = ad_d; req_data = data_b; req_decrypt = 1'b1;
      run_job(1'b1, lat, st_lat, st_len, fall_lat, falls, rr_seen);
      check("t6a_ready_low", 256'(rr_seen), 256'(0));
      check("t6a_rst_pulse", 256'(falls), 256'(1));
      check_result("t6a", key_2, nonce_2, ad_2, data_a, 1'b0);
      release_resp("t6a");
      run_job(1'b0, lat, st_lat, st_len, fall_lat, falls, rr_seen);
      check("t6b_latency",  256'(lat), 256'(LAT));
      check("t6b_rst_fall", 256'(fall_lat), 256'(2));
      check_result("t6b", key_d, nonce_d, ad_d, data_b, 1'b1);
      release_resp("t6b");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
